// File: rtl/game_board_if.sv
// game_board_if: shared move bus from the turn owner plus board/referee status back to it
interface game_board_if;
  logic [3:0]      update_loc;
  logic            submit;
  logic            new_game;
  logic [8:0][1:0] board_state;
  logic            turn;
  logic [3:0]      move_count;
  logic [1:0]      winner;
  logic            game_over;
  logic            move_err;
  modport master (
    output update_loc, submit, new_game,
    input  board_state, turn, move_count, winner, game_over, move_err
  );
  modport slave (
    input  update_loc, submit, new_game,
    output board_state, turn, move_count, winner, game_over, move_err
  );
endinterface

// File: rtl/game_board.sv
// game_board: authoritative tic-tac-toe referee committing legal moves, detecting win/draw and passing the turn
module game_board #(
  parameter logic FIRST_TURN    = 1'b0,
  parameter int   SETTLE_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  game_board_if.slave bus
);
  typedef enum logic [1:0] {S_SETTLE, S_WAIT, S_CHECK, S_OVER} state_t;
  localparam logic [1:0] CELL_X = 2'b01;
  localparam logic [1:0] CELL_O = 2'b10;
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  state_t          r_state, w_state;
  logic [7:0]      r_cnt, w_cnt;
  logic [8:0][1:0] r_board, w_board;
  logic [3:0]      r_count, w_count;
  logic [1:0]      r_winner, w_winner;
  logic            r_turn, w_turn, r_err, w_err, r_armed, w_armed;
  logic            r_submit_q, r_new_game_q;
  logic            w_sub, w_ng, w_sub_edge, w_ng_edge, w_loc_ok, w_legal, w_enter_settle;
  logic [3:0]      w_idx;
  logic [1:0]      w_sym;

  function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] s);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = b[i] == s;
    return (&m[2:0]) | (&m[5:3]) | (&m[8:6]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // a floating or unknown strobe is treated as deasserted
  assign w_sub      = bus.submit === 1'b1;
  assign w_ng       = bus.new_game === 1'b1;
  assign w_sub_edge = w_sub & ~r_submit_q & r_armed;
  assign w_ng_edge  = w_ng & ~r_new_game_q;
  assign w_sym      = r_turn ? CELL_O : CELL_X;
  assign w_loc_ok   = bus.update_loc <= 4'd8;
  assign w_idx      = w_loc_ok ? bus.update_loc : 4'd0;
  assign w_legal    = w_loc_ok && r_board[w_idx] == 2'b00;

  // next-state: new_game outranks everything, then the per-state referee rules
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_board  = r_board;
    w_count  = r_count;
    w_winner = r_winner;
    w_turn   = r_turn;
    w_err    = 1'b0;
    if (w_ng_edge) begin
      w_state  = S_SETTLE;
      w_cnt    = SETTLE_LOAD;
      w_board  = '0;
      w_count  = 4'd0;
      w_winner = 2'b00;
      w_turn   = FIRST_TURN;
    end else begin
      case (r_state)
        S_SETTLE: begin
          w_state = r_cnt == 8'd0 ? S_WAIT : S_SETTLE;
          w_cnt   = r_cnt == 8'd0 ? r_cnt : r_cnt - 8'd1;
        end
        S_WAIT: if (w_sub_edge) begin
          if (w_legal) begin
            w_board[w_idx] = w_sym;
            w_count        = r_count + 4'd1;
            w_state        = S_CHECK;
          end else w_err = 1'b1;
        end
        S_CHECK: begin
          if (has_line(r_board, w_sym)) begin
            w_winner = w_sym;
            w_state  = S_OVER;
          end else if (r_count == 4'd9) begin
            w_winner = 2'b11;
            w_state  = S_OVER;
          end else begin
            w_turn  = ~r_turn;
            w_cnt   = SETTLE_LOAD;
            w_state = S_SETTLE;
          end
        end
        default: ;
      endcase
    end
  end

  // arming requires submit to be seen low after each handover into SETTLE
  assign w_enter_settle = w_state == S_SETTLE && (r_state != S_SETTLE || w_ng_edge);
  assign w_armed        = w_enter_settle ? 1'b0 : (w_sub ? r_armed : 1'b1);

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_SETTLE;
      r_cnt        <= SETTLE_LOAD;
      r_board      <= '0;
      r_count      <= 4'd0;
      r_winner     <= 2'b00;
      r_turn       <= FIRST_TURN;
      r_err        <= 1'b0;
      r_armed      <= 1'b0;
      r_submit_q   <= 1'b0;
      r_new_game_q <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_board      <= w_board;
      r_count      <= w_count;
      r_winner     <= w_winner;
      r_turn       <= w_turn;
      r_err        <= w_err;
      r_armed      <= w_armed;
      r_submit_q   <= w_sub;
      r_new_game_q <= w_ng;
    end
  end

  assign bus.board_state = r_board;
  assign bus.turn        = r_turn;
  assign bus.move_count  = r_count;
  assign bus.winner      = r_winner;
  assign bus.game_over   = r_state == S_OVER;
  assign bus.move_err    = r_err;
endmodule

// File: tb/tb_game_board.sv
// tb_game_board: randomized scoreboard bench for game_board against a rule-level tic-tac-toe model
module tb_game_board;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_board_if bus();
  game_board #(.FIRST_TURN(1'b0), .SETTLE_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic            err;
    logic [8:0][1:0] board;
    logic            turn;
    logic [3:0]      count;
    logic [1:0]      winner;
    logic            over;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cells[9];
  int m_turn, m_count, m_winner;
  bit m_over;
  localparam int LN[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0][1:0] pack_board();
    logic [8:0][1:0] b;
    for (int i = 0; i < 9; i++) b[i] = 2'(cells[i]);
    return b;
  endfunction

  function automatic void push(input bit err);
    exp_t e;
    e.err = err; e.board = pack_board(); e.turn = 1'(m_turn);
    e.count = 4'(m_count); e.winner = 2'(m_winner); e.over = m_over;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) cells[i] = 0;
    m_turn = 0; m_count = 0; m_winner = 0; m_over = 0;
  endfunction

  function automatic void model_move(input int loc);
    int sym;
    bit win;
    if (m_over) return;
    if (loc > 8 || cells[loc] != 0) begin push(1); return; end
    sym = m_turn ? 2 : 1;
    cells[loc] = sym;
    m_count++;
    win = 0;
    for (int l = 0; l < 8; l++)
      if (cells[LN[l][0]] == sym && cells[LN[l][1]] == sym && cells[LN[l][2]] == sym) win = 1;
    if (win) begin m_winner = sym; m_over = 1; end
    else if (m_count == 9) begin m_winner = 3; m_over = 1; end
    else m_turn ^= 1;
    push(0);
  endfunction

  function automatic void model_new_game();
    bit dirty;
    dirty = m_count > 0;
    model_reset();
    if (dirty) push(0);
  endfunction

  task automatic move(input int loc);
    @(negedge clk);
    model_move(loc);
    bus.update_loc = 4'(loc);
    bus.submit = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic new_game();
    @(negedge clk);
    model_new_game();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // monitor: any move_err pulse or board change is a DUT response; compare once CHECK has resolved
  initial begin
    logic [8:0][1:0] prev;
    logic err;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin prev = '0; continue; end
      if (bus.move_err === 1'b1 || bus.board_state !== prev) begin
        err = bus.move_err;
        @(negedge clk);
        if (q.size() == 0) check("unexpected_event", 1, 0);
        else begin
          e = q.pop_front();
          check("move_err", 32'(err), 32'(e.err));
          check("board_state", 32'(bus.board_state), 32'(e.board));
          check("turn", 32'(bus.turn), 32'(e.turn));
          check("move_count", 32'(bus.move_count), 32'(e.count));
          check("winner", 32'(bus.winner), 32'(e.winner));
          check("game_over", 32'(bus.game_over), 32'(e.over));
        end
        prev = bus.board_state;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.update_loc = 4'd0;
    bus.submit = 1'b0;
    bus.new_game = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_board", 32'(bus.board_state), 0);
    check("rst_turn", 32'(bus.turn), 0);
    check("rst_count", 32'(bus.move_count), 0);
    check("rst_winner", 32'(bus.winner), 0);
    check("rst_over", 32'(bus.game_over), 0);
    check("rst_err", 32'(bus.move_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    // X at centre, then a fresh submit edge during the SETTLE handover must be dropped
    @(negedge clk);
    model_move(4);
    bus.update_loc = 4'd4;
    bus.submit = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    @(negedge clk);
    bus.update_loc = 4'd0;
    bus.submit = 1'b1;
    repeat (5) @(negedge clk);
    bus.submit = 1'b0;
    repeat (4) @(negedge clk);
    check("settle_turn", 32'(bus.turn), 1);
    check("settle_board", 32'(bus.board_state), 32'(pack_board()));
    // occupied cell and out-of-range index
    move(4);
    move(9);
    // X wins on the top row
    new_game();
    move(0); move(4); move(1); move(5); move(2);
    move(8); move(6);
    // full board, no line
    new_game();
    move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6); move(8);
    move(3);
    // new_game and submit edges together: the move is dropped
    new_game();
    move(4);
    @(negedge clk);
    model_new_game();
    bus.update_loc = 4'd0;
    bus.submit = 1'b1;
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    bus.new_game = 1'b0;
    repeat (3) @(negedge clk);
    move(0);
    // asynchronous reset mid-game
    new_game();
    move(0); move(4); move(8);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_board", 32'(bus.board_state), 0);
    check("async_turn", 32'(bus.turn), 0);
    check("async_count", 32'(bus.move_count), 0);
    check("async_winner", 32'(bus.winner), 0);
    check("async_over", 32'(bus.game_over), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    // random play with occasional restarts
    repeat (300) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0 || (m_over && r < 6)) new_game();
      else move(int'($urandom_range(0, 10)));
    end
    repeat (10) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_board.md
Name: game_board

Overview:
- Authoritative board/referee stage directly downstream of the AI and player input blocks.
- Consumes the shared update_loc / submit / game-reset bus (driven by whichever side owns the turn) and commits legal moves into the board register.
- Detects win/draw and toggles turn.
- board_state and turn feed back to the AI and display.

Parameters:
FIRST_TURN, 1'b0 (`TURN_PLAYER), side that moves first after reset / new game
SETTLE_CYCLES, 2, cycles submit is ignored after a turn change (bus ownership handover)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
update_loc  input  4 (`INDEX_T)  cell index 0..8, row-major, 4 = centre
submit  input  1 (`FLAG_T)  move strobe from the turn owner; counts as asserted only when exactly 1 (z/x = 0)
new_game  input  1 (`FLAG_T)  game reset request from the turn owner
board_state  output  9 x 2 (`BOARD_T `STATE_T)  cell i = board_state[i]; `CELL_BLANK=00, `CELL_X=01, `CELL_O=10
turn  output  1 (`FLAG_T)  0 = player (X), 1 = `TURN_AI (O)
move_count  output  4  committed moves, 0..9
winner  output  2  00 none, 01 X, 10 O, 11 draw
game_over  output  1  high while in OVER
move_err  output  1  one-cycle pulse on rejected move

Behaviour:
- rst (async) / reset values: all cells `CELL_BLANK, turn=FIRST_TURN, move_count=0, winner=00, game_over=0, move_err=0, state=SETTLE, settle counter=SETTLE_CYCLES, armed=0, submit_q=0, new_game_q=0.
- Inputs submit and new_game are registered (submit_q, new_game_q) for edge detection. Event = current 1 and _q 0.
- armed: cleared on every entry to SETTLE. Set on any cycle submit samples 0. Submit edges count only when armed=1.
- States: SETTLE, WAIT_MOVE, CHECK, OVER.
- SETTLE:
  - Counter decrements each cycle.
  - At 0, go to WAIT_MOVE.
  - Submit edges here are discarded, with no move_err.
- WAIT_MOVE, on an armed submit edge:
  - Illegal move (update_loc > 8 or target cell not blank): move_err=1 for exactly one cycle. Board, turn and state are unchanged.
  - Legal move: on the same edge, write the cell with X if turn=0 or O if turn=1, increment move_count, go to CHECK.
  - Latency: board_state shows the new symbol 1 cycle after the sampled submit edge.
- CHECK (1 cycle) uses the registered board.
  - Evaluate 8 lines: rows 012/345/678, cols 036/147/258, diags 048/246.
  - Line of the mover's symbol: winner = mover symbol, game_over=1, go to OVER.
  - Otherwise, if move_count=9: winner=11, go to OVER.
  - Otherwise: toggle turn, load counter, go to SETTLE.
  - Win takes priority over draw when the 9th move completes a line.
- OVER: board, winner and turn frozen. Submit ignored, no move_err.
- new_game edge, in any state:
  - Clears board, move_count and winner. game_over=0, turn=FIRST_TURN, go to SETTLE.
  - Beats a submit edge in the same cycle; that move is dropped.
- In CHECK, a new_game edge wins over the win/draw evaluation.
- move_count never exceeds 9 and never wraps.
- Only one move is committed per turn: after the commit, submit edges are ignored until the next SETTLE→WAIT_MOVE.

Test Plan:
- rst mid-game (3 moves committed) → all cells blank, turn=0, move_count=0, winner=00 immediately (async, before next clk edge).
- Player submits loc 4 → cell4=01 one cycle later, CHECK, turn=1 after CHECK. A submit edge held during the following SETTLE_CYCLES=2 → ignored.
- Submit loc 4 again (occupied), then loc 9 → one move_err pulse each; board and turn unchanged.
- X at 0,1,2 interleaved with O at 4,5 → winner=01, game_over=1. Further submits ignored, board frozen.
- Full board, no line (X 0,2,3,7,8; O 1,4,5,6) → after the 9th move, winner=11, move_count=9.
- new_game and submit edges in the same cycle in WAIT_MOVE → board cleared, move dropped, turn=FIRST_TURN, SETTLE entered.
